// File: rtl/amf_pkg.sv
// amf_pkg: shared definitions for the adaptive median filter output stage.
//   - mode encodings for the filter mode input
//   - amf_level_w(): width of a window-level index, max(1, clog2(levels))
package amf_pkg;

  localparam logic [1:0] AMF_MODE_ADAPT  = 2'b00;
  localparam logic [1:0] AMF_MODE_BYPASS = 2'b01;
  localparam logic [1:0] AMF_MODE_FIXED  = 2'b10;
  localparam logic [1:0] AMF_MODE_RSVD   = 2'b11;

  function automatic int amf_level_w(input int num_levels);
    return (num_levels > 1) ? $clog2(num_levels) : 1;
  endfunction

endpackage

// File: rtl/amf_level_encoder.sv
// amf_level_encoder: combinational lowest-set-bit priority encoder.
// Ports:
//   a_ok  in  N  per-level "median is not an impulse" flags
//   idx   out W  index of the lowest set bit (0 when none set)
//   found out 1  at least one bit of a_ok is set
module amf_level_encoder #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] a_ok,
  output logic [W-1:0] idx,
  output logic         found
);

  // Walk from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (a_ok[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amf_output_stage.sv
// amf_output_stage: two-stage valid/ready output stage of the adaptive median
// filter. Picks the window level and chooses between the original pixel and
// that level's median, then counts replaced pixels (saturating).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake
//   pix, med, a_ok, b_ok       centre pixel, per-level medians and level flags
//   mode, fix_level            filter mode and level for fixed mode
//   out_valid/out_ready        output handshake
//   out_pix, out_level,        filtered pixel, decision level,
//   out_replaced               median-chosen flag
//   cnt_clr, replaced_cnt      clear and value of the replaced-pixel counter
module amf_output_stage
  import amf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LEVELS = 3,
  parameter int CNT_WIDTH  = 16,
  localparam int LEVEL_W   = amf_level_w(NUM_LEVELS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          pix,
  input  logic [NUM_LEVELS*DATA_WIDTH-1:0] med,
  input  logic [NUM_LEVELS-1:0]          a_ok,
  input  logic [NUM_LEVELS-1:0]          b_ok,
  input  logic [1:0]                     mode,
  input  logic [LEVEL_W-1:0]             fix_level,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_pix,
  output logic [LEVEL_W-1:0]             out_level,
  output logic                           out_replaced,
  input  logic                           cnt_clr,
  output logic [CNT_WIDTH-1:0]           replaced_cnt
);

  logic [LEVEL_W-1:0]    enc_idx;
  logic                  enc_found;
  logic [LEVEL_W-1:0]    fix_clamped;
  logic [LEVEL_W-1:0]    dec_level;
  logic                  dec_rep;
  logic                  b_sel;
  logic [DATA_WIDTH-1:0] med_sel;

  logic                  s1_valid;
  logic [LEVEL_W-1:0]    s1_level;
  logic [DATA_WIDTH-1:0] s1_pix;
  logic [DATA_WIDTH-1:0] s1_med;
  logic                  s1_rep;
  logic                  s1_adv;
  logic                  in_fire;

  amf_level_encoder #(
    .N (NUM_LEVELS),
    .W (LEVEL_W)
  ) u_enc (
    .a_ok  (a_ok),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always_comb begin
    fix_clamped = fix_level;
    if (int'(fix_level) >= NUM_LEVELS) fix_clamped = LEVEL_W'(NUM_LEVELS - 1);

    b_sel = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (enc_idx == LEVEL_W'(i)) b_sel = b_ok[i];
    end

    dec_level = '0;
    dec_rep   = 1'b0;
    case (mode)
      AMF_MODE_ADAPT: begin
        if (enc_found) begin
          dec_level = enc_idx;
          dec_rep   = ~b_sel;
        end else begin
          // No level had a trustworthy median: fall back to the largest window.
          dec_level = LEVEL_W'(NUM_LEVELS - 1);
          dec_rep   = 1'b1;
        end
      end
      AMF_MODE_FIXED: begin
        dec_level = fix_clamped;
        dec_rep   = 1'b1;
      end
      default: begin
        dec_level = '0;
        dec_rep   = 1'b0;
      end
    endcase

    med_sel = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (dec_level == LEVEL_W'(i)) med_sel = med[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage 2 (the output register) is the only consumer of stage 1, so stage 1
  // advances whenever the output slot is empty or being drained.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_level     <= '0;
      s1_pix       <= '0;
      s1_med       <= '0;
      s1_rep       <= 1'b0;
      out_valid    <= 1'b0;
      out_pix      <= '0;
      out_level    <= '0;
      out_replaced <= 1'b0;
      replaced_cnt <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_level <= dec_level;
        s1_pix   <= pix;
        s1_med   <= med_sel;
        s1_rep   <= dec_rep;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_pix      <= s1_rep ? s1_med : s1_pix;
          out_level    <= s1_level;
          out_replaced <= s1_rep;
        end
      end

      if (cnt_clr) begin
        replaced_cnt <= '0;
      end else if (out_valid && out_ready && out_replaced && (replaced_cnt != '1)) begin
        replaced_cnt <= replaced_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_amf_output_stage.sv
module tb_amf_output_stage;
  import amf_pkg::*;

  localparam int DW = 8;
  localparam int NL = 3;
  localparam int CW = 4;
  localparam int LW = amf_level_w(NL);
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     pix = '0;
  logic [NL*DW-1:0]  med = '0;
  logic [NL-1:0]     a_ok = '0;
  logic [NL-1:0]     b_ok = '0;
  logic [1:0]        mode = 2'b00;
  logic [LW-1:0]     fix_level = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_pix;
  logic [LW-1:0]     out_level;
  logic              out_replaced;
  logic              cnt_clr = 1'b0;
  logic [CW-1:0]     replaced_cnt;

  amf_output_stage #(
    .DATA_WIDTH (DW),
    .NUM_LEVELS (NL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pix          (pix),
    .med          (med),
    .a_ok         (a_ok),
    .b_ok         (b_ok),
    .mode         (mode),
    .fix_level    (fix_level),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pix      (out_pix),
    .out_level    (out_level),
    .out_replaced (out_replaced),
    .cnt_clr      (cnt_clr),
    .replaced_cnt (replaced_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] p;
    logic [LW-1:0] l;
    logic          r;
  } exp_t;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  int            cnt_m = 0;
  int            n_out = 0;
  logic          acc = 1'b0;
  logic          obs_in_ready = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] hold_p = '0;
  logic [LW-1:0] hold_l = '0;
  logic          hold_r = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decision: pick the level from the flags with plain arithmetic.
  function automatic exp_t model(input logic [DW-1:0] p, input logic [NL*DW-1:0] m,
                                 input logic [NL-1:0] a, input logic [NL-1:0] b,
                                 input logic [1:0] md, input int fx);
    exp_t e;
    int   lv;
    if (md == 2'b00) begin
      lv = -1;
      for (int i = NL - 1; i >= 0; i--) if (a[i]) lv = i;
      if (lv < 0) begin
        lv  = NL - 1;
        e.r = 1'b1;
      end else begin
        e.r = !b[lv];
      end
      e.p = e.r ? m[lv*DW +: DW] : p;
      e.l = LW'(lv);
    end else if (md == 2'b10) begin
      lv  = (fx >= NL) ? NL - 1 : fx;
      e.p = m[lv*DW +: DW];
      e.l = LW'(lv);
      e.r = 1'b1;
    end else begin
      e.p = p;
      e.l = '0;
      e.r = 1'b0;
    end
    return e;
  endfunction

  // One clock: check at the negedge, update the models for the coming edge,
  // return 1ns after the edge so the caller can drive the next inputs.
  task automatic step();
    logic xo, xi;
    exp_t f;
    @(negedge clk);
    xo = out_valid && out_ready && rst_n;
    xi = in_valid && in_ready && rst_n;
    obs_in_ready = in_ready;
    chk("replaced_cnt", 32'(replaced_cnt), 32'(cnt_m));
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pix", 32'(out_pix), 32'(hold_p));
      chk("stall_level", 32'(out_level), 32'(hold_l));
      chk("stall_rep", 32'(out_replaced), 32'(hold_r));
    end
    if (out_valid) begin
      chk("out_has_beat", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        f = q[0];
        chk("out_pix", 32'(out_pix), 32'(f.p));
        chk("out_level", 32'(out_level), 32'(f.l));
        chk("out_replaced", 32'(out_replaced), 32'(f.r));
      end
    end
    prev_stall = out_valid && !out_ready && rst_n;
    hold_p = out_pix;
    hold_l = out_level;
    hold_r = out_replaced;
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (cnt_clr) cnt_m = 0;
      else if (xo && q.size() != 0 && q[0].r && cnt_m < CNT_MAX) cnt_m++;
      if (xo && q.size() != 0) begin
        void'(q.pop_front());
        n_out++;
      end
      if (xi) q.push_back(model(pix, med, a_ok, b_ok, mode, int'(fix_level)));
    end
    acc = xi;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [DW-1:0] p, input logic [NL*DW-1:0] m,
                        input logic [NL-1:0] a, input logic [NL-1:0] b, input logic [1:0] md,
                        input logic [LW-1:0] fx, input logic [DW-1:0] ep, input logic [LW-1:0] el,
                        input logic er, input int ecnt);
    pix = p; med = m; a_ok = a; b_ok = b; mode = md; fix_level = fx;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_not_early"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pix"}, 32'(out_pix), 32'(ep));
    chk({tag, "_level"}, 32'(out_level), 32'(el));
    chk({tag, "_rep"}, 32'(out_replaced), 32'(er));
    step();
    chk({tag, "_cnt"}, 32'(replaced_cnt), 32'(ecnt));
  endtask

  task automatic flush();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("flush_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int sent;
    logic [NL*DW-1:0] mset;
    mset = {8'd30, 8'd20, 8'd10};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pix", 32'(out_pix), 32'd0);
    chk("rst_out_level", 32'(out_level), 32'd0);
    chk("rst_out_rep", 32'(out_replaced), 32'd0);
    chk("rst_cnt", 32'(replaced_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    single("hit",     8'd255, mset, 3'b110, 3'b000, AMF_MODE_ADAPT,  2'd0, 8'd20,  2'd1, 1'b1, 1);
    single("keep",    8'd100, mset, 3'b001, 3'b001, AMF_MODE_ADAPT,  2'd0, 8'd100, 2'd0, 1'b0, 1);
    single("exhaust", 8'd7,   mset, 3'b000, 3'b111, AMF_MODE_ADAPT,  2'd0, 8'd30,  2'd2, 1'b1, 2);
    single("fixclmp", 8'd9,   mset, 3'b001, 3'b000, AMF_MODE_FIXED,  2'd3, 8'd30,  2'd2, 1'b1, 3);
    single("fix1",    8'd9,   mset, 3'b100, 3'b000, AMF_MODE_FIXED,  2'd1, 8'd20,  2'd1, 1'b1, 4);
    single("rsvd",    8'd77,  mset, 3'b010, 3'b000, AMF_MODE_RSVD,   2'd2, 8'd77,  2'd0, 1'b0, 4);
    single("bypass",  8'd55,  mset, 3'b000, 3'b000, AMF_MODE_BYPASS, 2'd2, 8'd55,  2'd0, 1'b0, 4);

    // Backpressure: 6 beats, out_ready low for cycles 3..7.
    sent = 0;
    n_out = 0;
    mode = AMF_MODE_BYPASS;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid = (sent < 6);
      pix = 8'(40 + sent);
      step();
      if (c == 2) chk("bp_in_ready_c2", 32'(obs_in_ready), 32'd1);
      if (c == 3) chk("bp_in_ready_low", 32'(obs_in_ready), 32'd0);
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("bp_beats_out", 32'(n_out), 32'd6);
    flush();

    // Randomised traffic with random backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      pix       = DW'($urandom);
      med       = (NL*DW)'($urandom);
      a_ok      = NL'($urandom);
      b_ok      = NL'($urandom);
      mode      = 2'($urandom);
      fix_level = LW'($urandom);
      step();
    end
    cnt_clr = 1'b0;
    flush();

    // Counter saturation at 15, then clear racing a replaced transfer.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cnt_cleared", 32'(replaced_cnt), 32'd0);
    sent = 0;
    mode = AMF_MODE_FIXED;
    med = mset;
    for (int c = 0; c < 40 && sent < 20; c++) begin
      in_valid = 1'b1;
      fix_level = LW'(c);
      step();
      if (acc) sent++;
    end
    flush();
    chk("cnt_saturated", 32'(replaced_cnt), 32'd15);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_race_valid", 32'(out_valid & out_replaced), 32'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_race_cnt", 32'(replaced_cnt), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    mode = AMF_MODE_FIXED;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pix", 32'(out_pix), 32'd0);
    chk("mid_rst_level", 32'(out_level), 32'd0);
    chk("mid_rst_rep", 32'(out_replaced), 32'd0);
    chk("mid_rst_cnt", 32'(replaced_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    single("post_rst", 8'd3, mset, 3'b010, 3'b010, AMF_MODE_ADAPT, 2'd0, 8'd3, 2'd1, 1'b0, 0);
    single("post_rst2", 8'd3, mset, 3'b010, 3'b000, AMF_MODE_ADAPT, 2'd0, 8'd20, 2'd1, 1'b1, 1);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amf_output_stage.md
# amf_output_stage

Pipelined, parametrised output stage of the adaptive median filter. Takes per-pixel results from the window-level comparators: the original pixel, one median per window level, and the level-A/level-B flags. It performs the full adaptive decision across NUM_LEVELS window sizes, with valid/ready flow control and a saturating count of replaced pixels. It sits between the median/min-max comparator bank and the pixel writeback.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- NUM_LEVELS, 3, number of window levels (level 0 = smallest window); range 1..8
- CNT_WIDTH, 16, width of replaced-pixel counter
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- pix  in  DATA_WIDTH  original centre pixel z_xy
- med  in  NUM_LEVELS*DATA_WIDTH  median per level; level i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- a_ok  in  NUM_LEVELS  bit i: zmin_i < zmed_i < zmax_i at level i
- b_ok  in  NUM_LEVELS  bit i: zmin_i < z_xy < zmax_i at level i
- mode  in  2  00 adaptive, 01 bypass, 10 fixed-level median, 11 reserved (treated as bypass); quasi-static
- fix_level  in  LEVEL_W  level used in mode 10; values >= NUM_LEVELS clamp to NUM_LEVELS-1
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_pix  out  DATA_WIDTH  filtered pixel
- out_level  out  LEVEL_W  level the decision was taken at
- out_replaced  out  1  out_pix differs in source from pix (median chosen)
- cnt_clr  in  1  synchronous clear of replaced_cnt
- replaced_cnt  out  CNT_WIDTH  saturating count of transferred beats with out_replaced=1

## Operation
- Adaptive (mode 00): L = lowest i with a_ok[i]=1.
  - If L exists: if b_ok[L], output pix and set replaced=0; else output med[L] and set replaced=1.
  - If no a_ok bit is set: L = NUM_LEVELS-1; output med[L] with replaced=1.
- Bypass (01/11): out_pix=pix, out_level=0, replaced=0.
- Fixed (10): L = clamped fix_level; out_pix=med[L], replaced=1.
- Stage 1 registers L, pix, med[L] and the decision bit. Stage 2 registers out_pix, out_level, out_replaced.
- Counter increments on out_valid && out_ready && out_replaced, saturating at all-ones. cnt_clr has priority: clear plus simultaneous increment gives 0.

## Timing
- Latency 2 cycles from the accepted input beat to out_valid, with no stalls; full throughput of 1 beat/cycle.
- Transfer occurs on valid && ready at both ports. Stage n loads when it is empty or its contents advance in the same cycle.
- in_ready = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready. in_ready is combinational from out_ready.
- While out_valid=1 and out_ready=0, out_pix/out_level/out_replaced hold stable. out_valid never drops without a transfer.
- Reset (rst_n=0 at a clk edge):
  - s1_valid, s2_valid, out_valid = 0; out_pix, out_level, out_replaced, replaced_cnt = 0.
  - Reset mid-stream discards in-flight beats. in_ready reads 1 the cycle after reset.
- mode/fix_level are sampled into stage 1 with each beat. A change only affects beats accepted after it.

## Structure
- Shared package amf_pkg: mode encodings (AMF_MODE_ADAPT, AMF_MODE_BYPASS, AMF_MODE_FIXED) and LEVEL_W = max(1, clog2(NUM_LEVELS)).
- Sub-module amf_level_encoder: combinational lowest-set-bit priority encoder over a_ok. Outputs index and found flag.
- The two-slot pipeline and counter live in the top module.

## Test plan
- Adaptive hit: DATA_WIDTH=8, NUM_LEVELS=3, pix=255, med={30,20,10}, a_ok=3'b110, b_ok=3'b000 -> two cycles later out_pix=20, out_level=1, out_replaced=1, replaced_cnt=1.
- Pixel kept: pix=100, a_ok=3'b001, b_ok=3'b001 -> out_pix=100, out_level=0, replaced=0, counter unchanged.
- Exhaustion and modes:
  - a_ok=0 -> out_pix=med[2], out_level=2, replaced=1.
  - mode=10, fix_level=3 -> clamps to level 2.
  - mode=11 -> out_pix=pix.
- Backpressure: stream 6 beats, hold out_ready=0 for cycles 3-7. Required response:
  - in_ready falls after 2 beats are buffered.
  - Outputs are stable during the stall.
  - All 6 beats emerge in order with no loss or duplication.
- Counter: CNT_WIDTH=4, 20 replaced transfers -> replaced_cnt=15. Assert cnt_clr together with a replaced transfer -> replaced_cnt=0.
- Reset mid-stream: rst_n=0 for 1 cycle with both stages full -> out_valid=0 and all outputs 0 next cycle, in_ready=1. The next beat appears with latency 2.
